processor_run_ctrl: RTL and testbench



---
 rtl/processor_run_ctrl_pkg.sv | 30 +++
 rtl/processor_run_ctrl_end_op_latch.sv | 30 +++
 rtl/processor_run_ctrl.sv | 138 +++++++++++++
 tb/tb_processor_run_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/processor_run_ctrl_pkg.sv
// Shared definitions for the processor run controller: state encoding,
// core count and the core-select clamp helpers.
package processor_run_ctrl_pkg;

    localparam int NUM_CORES = 4;
    localparam logic [2:0] CORE_SEL_MAX = 3'd3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_RUN    = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } run_state_t;

    // Requested core count minus one, limited to the cores that exist.
    function automatic logic [2:0] clamp_cores(input logic [2:0] cfg);
        return (cfg > CORE_SEL_MAX) ? CORE_SEL_MAX : cfg;
    endfunction

    // Active-core mask: the low sel+1 bits set.
    function automatic logic [NUM_CORES-1:0] cores_mask(input logic [2:0] sel);
        logic [NUM_CORES-1:0] m;
        for (int i = 0; i < NUM_CORES; i++) begin
            m[i] = (3'(i) <= sel);
        end
        return m;
    endfunction

endpackage

// File: rtl/processor_run_ctrl_end_op_latch.sv
// Per-core sticky completion flag with the instruction captured at the
// moment the core first reports end_op.
module end_op_latch #(
    parameter int INS_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             en,
    input  logic             end_op,
    input  logic [INS_W-1:0] ins,
    output logic             fin,
    output logic [INS_W-1:0] fin_ins
);

    // First enabled end_op sets the flag and freezes the instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fin     <= 1'b0;
            fin_ins <= '0;
        end else if (clear) begin
            fin     <= 1'b0;
            fin_ins <= '0;
        end else if (en && end_op && !fin) begin
            fin     <= 1'b1;
            fin_ins <= ins;
        end
    end

endmodule

// File: rtl/processor_run_ctrl.sv
// Host-side run controller: launches a run on the selected cores, collects
// per-core completions, drains, and reports run length and final
// instructions. Handshake: start is a level sampled only in IDLE; done is a
// one-cycle pulse and results stay valid until the next launch.
module processor_run_ctrl
    import processor_run_ctrl_pkg::*;
#(
    parameter int NCORES         = NUM_CORES,
    parameter int INS_W          = 8,
    parameter int CNT_W          = 24,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int DRAIN_CYCLES   = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [2:0]        cfg_cores,
    input  logic [NCORES-1:0] end_op,
    input  logic [INS_W-1:0]  ins1,
    input  logic [INS_W-1:0]  ins2,
    input  logic [INS_W-1:0]  ins3,
    input  logic [INS_W-1:0]  ins4,
    output logic [2:0]        core_sel,
    output logic              core_run,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [CNT_W-1:0]  cycles,
    output logic [NCORES-1:0] fin_mask,
    output logic [INS_W-1:0]  fin_ins1,
    output logic [INS_W-1:0]  fin_ins2,
    output logic [INS_W-1:0]  fin_ins3,
    output logic [INS_W-1:0]  fin_ins4,
    output logic [2:0]        dbg_state
);

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

    run_state_t        state, state_next;
    logic [NCORES-1:0] mask;
    logic [DW-1:0]     drain_cnt;
    logic              launch, in_run, all_fin, hit_timeout;
    logic [NCORES-1:0] new_cap;
    logic [CNT_W-1:0]  cycles_inc;
    logic [INS_W-1:0]  ins_arr     [NCORES];
    logic [INS_W-1:0]  fin_ins_arr [NCORES];

    assign launch      = (state == ST_IDLE) && start;
    assign in_run      = (state == ST_RUN);
    assign new_cap     = end_op & mask & ~fin_mask & {NCORES{in_run}};
    assign all_fin     = (((fin_mask | new_cap) & mask) == mask);
    assign cycles_inc  = (cycles == '1) ? cycles : cycles + 1'b1;
    assign hit_timeout = (cycles_inc >= TIMEOUT_VAL);

    assign core_run  = (state == ST_RUN) || (state == ST_DRAIN);
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);
    assign dbg_state = state;

    assign ins_arr[0] = ins1;
    assign ins_arr[1] = ins2;
    assign ins_arr[2] = ins3;
    assign ins_arr[3] = ins4;
    assign fin_ins1   = fin_ins_arr[0];
    assign fin_ins2   = fin_ins_arr[1];
    assign fin_ins3   = fin_ins_arr[2];
    assign fin_ins4   = fin_ins_arr[3];

    for (genvar i = 0; i < NCORES; i++) begin : g_latch
        end_op_latch #(.INS_W(INS_W)) u_latch (
            .clk     (clk),
            .rst_n   (rst_n),
            .clear   (launch),
            .en      (in_run && mask[i]),
            .end_op  (end_op[i]),
            .ins     (ins_arr[i]),
            .fin     (fin_mask[i]),
            .fin_ins (fin_ins_arr[i])
        );
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    // Next-state logic; completion takes priority over timeout.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (start) state_next = ST_LAUNCH;
            ST_LAUNCH: state_next = ST_RUN;
            ST_RUN: begin
                if (all_fin)          state_next = ST_DRAIN;
                else if (hit_timeout) state_next = ST_DONE;
            end
            ST_DRAIN:  if (drain_cnt == DRAIN_LAST) state_next = ST_DONE;
            ST_DONE:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Run configuration, latched once at launch and held for the run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_sel <= '0;
            mask     <= '0;
        end else if (launch) begin
            core_sel <= clamp_cores(cfg_cores);
            mask     <= cores_mask(clamp_cores(cfg_cores));
        end
    end

    // Saturating RUN-cycle counter and timeout flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycles  <= '0;
            timeout <= 1'b0;
        end else if (launch) begin
            cycles  <= '0;
            timeout <= 1'b0;
        end else if (in_run) begin
            cycles <= cycles_inc;
            if (!all_fin && hit_timeout) timeout <= 1'b1;
        end
    end

    // Drain counter: counts edges spent in DRAIN, zero elsewhere.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 drain_cnt <= '0;
        else if (state == ST_DRAIN) drain_cnt <= drain_cnt + 1'b1;
        else                        drain_cnt <= '0;
    end

endmodule

// File: tb/tb_processor_run_ctrl.sv
// Directed bench for processor_run_ctrl with a short timeout.
module tb_processor_run_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  cfg_cores;
    logic [3:0]  end_op;
    logic [7:0]  ins1, ins2, ins3, ins4;
    logic [2:0]  core_sel;
    logic        core_run, busy, done, timeout;
    logic [23:0] cycles;
    logic [3:0]  fin_mask;
    logic [7:0]  fin_ins1, fin_ins2, fin_ins3, fin_ins4;
    logic [2:0]  dbg_state;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    processor_run_ctrl #(
        .NCORES(4), .INS_W(8), .CNT_W(24), .TIMEOUT_CYCLES(50), .DRAIN_CYCLES(5)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_cores(cfg_cores),
        .end_op(end_op), .ins1(ins1), .ins2(ins2), .ins3(ins3), .ins4(ins4),
        .core_sel(core_sel), .core_run(core_run), .busy(busy), .done(done),
        .timeout(timeout), .cycles(cycles), .fin_mask(fin_mask),
        .fin_ins1(fin_ins1), .fin_ins2(fin_ins2), .fin_ins3(fin_ins3),
        .fin_ins4(fin_ins4), .dbg_state(dbg_state)
    );

    typedef struct {
        logic [2:0]  cfg;
        int          c1;
        logic [3:0]  e1;
        int          c2;
        logic [3:0]  e2;
        logic [2:0]  x_sel;
        logic [23:0] x_cycles;
        logic [3:0]  x_mask;
        logic        x_to;
        logic [31:0] x_ins;   // {fin_ins4, fin_ins3, fin_ins2, fin_ins1}
    } vec_t;

    vec_t tbl [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Per-cycle instruction pattern: core i (1..4) shows k + 16*i in RUN cycle k.
    task automatic drive_ins(input int k);
        ins1 = 8'(k + 16);
        ins2 = 8'(k + 32);
        ins3 = 8'(k + 48);
        ins4 = 8'(k + 64);
    endtask

    task automatic launch_run(input logic [2:0] cfg);
        @(negedge clk);
        cfg_cores = cfg;
        start     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start     = 1'b0;
        cfg_cores = cfg ^ 3'b111;  // later changes must be ignored
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        bit got_done;
        string tag;
        tag = $sformatf("v%0d", idx);
        launch_run(v.cfg);
        check({tag, "_launch_busy"}, 32'(busy), 32'd1);
        check({tag, "_launch_cycles"}, 32'(cycles), 32'd0);
        check({tag, "_launch_mask"}, 32'(fin_mask), 32'd0);
        check({tag, "_core_sel"}, 32'(core_sel), 32'(v.x_sel));
        @(posedge clk);
        @(negedge clk);
        check({tag, "_run_rise"}, 32'(core_run), 32'd1);
        got_done = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            end_op = ((k >= v.c1) ? v.e1 : 4'b0) | ((k >= v.c2) ? v.e2 : 4'b0);
            drive_ins(k);
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                got_done = 1'b1;
                break;
            end
        end
        check({tag, "_done_seen"}, 32'(got_done), 32'd1);
        check({tag, "_cycles"}, 32'(cycles), 32'(v.x_cycles));
        check({tag, "_fin_mask"}, 32'(fin_mask), 32'(v.x_mask));
        check({tag, "_timeout"}, 32'(timeout), 32'(v.x_to));
        check({tag, "_fin_ins"}, {fin_ins4, fin_ins3, fin_ins2, fin_ins1}, v.x_ins);
        end_op = 4'b0;
        @(posedge clk);
        @(negedge clk);
        check({tag, "_idle_after"}, 32'(busy), 32'd0);
        check({tag, "_held_cycles"}, 32'(cycles), 32'(v.x_cycles));
    endtask

    initial begin
        bit done_hit;

        tbl[0] = '{cfg: 3'd1, c1: 5, e1: 4'b1100, c2: 8, e2: 4'b0011, x_sel: 3'd1,
                   x_cycles: 24'd8, x_mask: 4'b0011, x_to: 1'b0, x_ins: 32'h0000_2818};
        tbl[1] = '{cfg: 3'd6, c1: 3, e1: 4'b0111, c2: 12, e2: 4'b1000, x_sel: 3'd3,
                   x_cycles: 24'd12, x_mask: 4'b1111, x_to: 1'b0, x_ins: 32'h4C33_2313};
        tbl[2] = '{cfg: 3'd3, c1: 2, e1: 4'b0111, c2: 999, e2: 4'b0000, x_sel: 3'd3,
                   x_cycles: 24'd50, x_mask: 4'b0111, x_to: 1'b1, x_ins: 32'h0032_2212};
        tbl[3] = '{cfg: 3'd0, c1: 1, e1: 4'b1111, c2: 999, e2: 4'b0000, x_sel: 3'd0,
                   x_cycles: 24'd1, x_mask: 4'b0001, x_to: 1'b0, x_ins: 32'h0000_0011};
        tbl[4] = '{cfg: 3'd2, c1: 7, e1: 4'b0100, c2: 9, e2: 4'b1011, x_sel: 3'd2,
                   x_cycles: 24'd9, x_mask: 4'b0111, x_to: 1'b0, x_ins: 32'h0037_2919};

        // Clock/reset.
        rst_n = 1'b0; start = 1'b0; cfg_cores = 3'd0; end_op = 4'b0;
        ins1 = 8'h0; ins2 = 8'h0; ins3 = 8'h0; ins4 = 8'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_outputs", {busy, done, core_run, timeout, fin_mask, core_sel, dbg_state},
              32'd0);
        check("rst_cycles", 32'(cycles), 32'd0);
        rst_n = 1'b1;

        // All four cores, staggered completions, start re-pulsed mid-run.
        launch_run(3'd3);
        @(posedge clk);
        @(negedge clk);
        for (int k = 1; k <= 40; k++) begin
            end_op = (k == 10) ? 4'b0001 : (k == 20) ? 4'b0010 :
                     (k == 30) ? 4'b0100 : (k == 40) ? 4'b1000 : 4'b0000;
            ins1 = (k == 10) ? 8'h11 : 8'hEE;
            ins2 = (k == 20) ? 8'h22 : 8'hEE;
            ins3 = (k == 30) ? 8'h33 : 8'hEE;
            ins4 = (k == 40) ? 8'h44 : 8'hEE;
            start = (k == 15);
            @(posedge clk);
            @(negedge clk);
        end
        end_op = 4'b0; start = 1'b0;
        check("all4_drain_run", 32'(core_run), 32'd1);
        for (int j = 1; j <= 6; j++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("all4_done_j%0d", j), 32'(done), (j == 5) ? 32'd1 : 32'd0);
            if (j == 4) check("all4_run_before_end", 32'(core_run), 32'd1);
            if (j == 5) check("all4_run_fall", 32'(core_run), 32'd0);
        end
        check("all4_cycles", 32'(cycles), 32'd40);
        check("all4_mask", 32'(fin_mask), 32'hF);
        check("all4_fin_ins", {fin_ins4, fin_ins3, fin_ins2, fin_ins1}, 32'h4433_2211);
        check("all4_timeout", 32'(timeout), 32'd0);
        check("all4_no_relaunch", 32'(busy), 32'd0);

        // Table-driven runs.
        for (int i = 0; i < 5; i++) run_vec(i, tbl[i]);

        // Reset in the middle of a run.
        launch_run(3'd3);
        @(posedge clk);
        @(negedge clk);
        for (int k = 1; k <= 10; k++) begin
            end_op = (k >= 3) ? 4'b0001 : 4'b0000;
            drive_ins(k);
            @(posedge clk);
            @(negedge clk);
        end
        check("mid_pre_mask", 32'(fin_mask), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_core_run", 32'(core_run), 32'd0);
        check("mid_outputs", {busy, done, timeout, fin_mask, core_sel}, 32'd0);
        check("mid_cycles", 32'(cycles), 32'd0);
        check("mid_fin_ins", {fin_ins4, fin_ins3, fin_ins2, fin_ins1}, 32'd0);
        done_hit = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) done_hit = 1'b1;
        end
        check("mid_no_done", 32'(done_hit), 32'd0);
        end_op = 4'b0;
        rst_n  = 1'b1;
        run_vec(9, tbl[3]);

        // Back-to-back: start held high across DONE.
        @(negedge clk);
        cfg_cores = 3'd0; start = 1'b1; end_op = 4'b0001;
        done_hit = 1'b0;
        for (int j = 0; j < 20; j++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                done_hit = 1'b1;
                break;
            end
        end
        check("b2b_done", 32'(done_hit), 32'd1);
        @(posedge clk);
        @(negedge clk);
        check("b2b_idle", 32'(dbg_state), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("b2b_relaunch", 32'(dbg_state), 32'd1);
        start = 1'b0;
        repeat (12) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
